// File: rtl/reg_spill_unit_pkg.sv
// Shared constants and the state type for the register spill/fill engine.
package reg_spill_unit_pkg;

  localparam int DEF_NUM_REGS    = 8;
  localparam int DEF_SEL_W       = 3;
  localparam int DEF_ADDR_STRIDE = 2;
  localparam int DATA_W          = 16;
  localparam int ADDR_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SV_RD,
    ST_SV_CAP,
    ST_SV_MEM,
    ST_RS_MEM,
    ST_RS_WR,
    ST_FIN
  } state_e;

endpackage

// File: rtl/reg_spill_unit_if.sv
// Start/status, register-file and memory signals of the spill unit in one bundle.
interface reg_spill_unit_if #(
  parameter int SEL_W = reg_spill_unit_pkg::DEF_SEL_W
);
  import reg_spill_unit_pkg::*;

  logic              start_save;
  logic              start_restore;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;

  logic              reg_en;
  logic              reg_wr_en;
  logic [SEL_W-1:0]  reg_sel;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  // mem_req is held with mem_we/mem_addr/mem_wdata stable until a rising
  // clock edge samples mem_ack=1; mem_ack is ignored while mem_req=0.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  state_e            dbg_state;

  modport master (
    input  start_save, start_restore, base_addr, reg_rdata, mem_rdata, mem_ack,
    output busy, done, reg_en, reg_wr_en, reg_sel, reg_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata, dbg_state
  );

  modport slave (
    output start_save, start_restore, base_addr, reg_rdata, mem_rdata, mem_ack,
    input  busy, done, reg_en, reg_wr_en, reg_sel, reg_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, dbg_state
  );

endinterface

// File: rtl/reg_spill_unit.sv
// Context save/restore engine: spills r0..NUM_REGS-1 to memory at base_addr or reloads them.
module reg_spill_unit #(
  parameter int NUM_REGS    = reg_spill_unit_pkg::DEF_NUM_REGS,
  parameter int SEL_W       = reg_spill_unit_pkg::DEF_SEL_W,
  parameter int ADDR_STRIDE = reg_spill_unit_pkg::DEF_ADDR_STRIDE
) (
  input logic            clk,
  input logic            rst,
  reg_spill_unit_if.master bus
);
  import reg_spill_unit_pkg::*;

  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);

  state_e            state_q;
  logic [SEL_W-1:0]  idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q, done_q, reg_en_q, reg_wr_en_q, mem_req_q, mem_we_q;
  logic [SEL_W-1:0]  reg_sel_q;
  logic [DATA_W-1:0] reg_wdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              last_d;
  logic [SEL_W-1:0]  idx_d;
  logic [ADDR_W-1:0] addr_d;

  assign last_d = (idx_q == LAST_IDX);
  assign idx_d  = idx_q + SEL_W'(1);
  assign addr_d = addr_q + STRIDE;

  // All outputs are registered: each is set on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reg_en_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      reg_sel_q   <= '0;
      reg_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q      <= 1'b0;
      reg_en_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_save) begin
            addr_q    <= bus.base_addr;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            reg_en_q  <= 1'b1;
            reg_sel_q <= '0;
            state_q   <= ST_SV_RD;
          end else if (bus.start_restore) begin
            addr_q     <= bus.base_addr;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.base_addr;
            state_q    <= ST_RS_MEM;
          end
        end
        ST_SV_RD: state_q <= ST_SV_CAP;
        ST_SV_CAP: begin
          mem_wdata_q <= bus.reg_rdata;
          mem_addr_q  <= addr_q;
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b1;
          state_q     <= ST_SV_MEM;
        end
        ST_SV_MEM: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (last_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              idx_q     <= idx_d;
              addr_q    <= addr_d;
              reg_en_q  <= 1'b1;
              reg_sel_q <= idx_d;
              state_q   <= ST_SV_RD;
            end
          end
        end
        ST_RS_MEM: begin
          if (bus.mem_ack) begin
            mem_req_q   <= 1'b0;
            reg_wdata_q <= bus.mem_rdata;
            reg_en_q    <= 1'b1;
            reg_wr_en_q <= 1'b1;
            reg_sel_q   <= idx_q;
            state_q     <= ST_RS_WR;
          end
        end
        ST_RS_WR: begin
          if (last_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_d;
            state_q    <= ST_RS_MEM;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reg_en    = reg_en_q;
  assign bus.reg_wr_en = reg_wr_en_q;
  assign bus.reg_sel   = reg_sel_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_reg_spill_unit.sv
// Bench for reg_spill_unit: register-file and memory models, a reference model and a scoreboard.
module tb_reg_spill_unit;
  import reg_spill_unit_pkg::*;

  localparam int NUM_REGS = DEF_NUM_REGS;
  localparam int SEL_W    = DEF_SEL_W;
  localparam int STRIDE   = DEF_ADDR_STRIDE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_spill_unit_if #(.SEL_W(SEL_W)) bus ();

  reg_spill_unit #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .ADDR_STRIDE(STRIDE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- register file model ----------------
  logic [15:0] rf     [NUM_REGS];
  logic [15:0] rf_pre [NUM_REGS];
  logic        rf_load = 1'b0;

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= rf_pre[i];
    end else if (bus.reg_en) begin
      if (bus.reg_wr_en) rf[bus.reg_sel] <= bus.reg_wdata;
      else               bus.reg_rdata   <= rf[bus.reg_sel];
    end
  end

  // ---------------- memory model ----------------
  logic [15:0] mem [logic [15:0]];
  logic        pl_mem = 1'b0;
  logic [15:0] pl_addr, pl_data;
  int          mem_delay = 0;

  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (pl_mem) mem[pl_addr] = pl_data;
      if (bus.mem_req) begin
        if (wcnt >= mem_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_we ? 16'h0 : (mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 16'h0);
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          wcnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_rf [NUM_REGS];
  logic [15:0] ref_mem [logic [15:0]];
  logic [32:0] exp_q  [$];   // {we, addr, wdata (0 for reads)}
  logic [18:0] rexp_q [$];   // {sel, data} register-file writes

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic model_save(input logic [15:0] base);
    logic [15:0] a;
    for (int i = 0; i < NUM_REGS; i++) begin
      a = base + 16'(i * STRIDE);
      exp_q.push_back({1'b1, a, ref_rf[i]});
      ref_mem[a] = ref_rf[i];
    end
  endtask

  task automatic model_restore(input logic [15:0] base, input int n);
    logic [15:0] a, d;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i * STRIDE);
      d = ref_rd(a);
      exp_q.push_back({1'b0, a, 16'h0});
      rexp_q.push_back({SEL_W'(i), d});
      ref_rf[i] = d;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          reg_wr_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [32:0] hold_val;

  always @(negedge clk) begin
    logic [32:0] act;
    logic [18:0] ract;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      act = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 16'h0};
      if (hold_pend) begin
        chk("req_held", {63'h0, bus.mem_req}, 64'h1);
        chk("req_stable", {31'h0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {31'h0, hold_val});
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_q.size() == 0) chk("unexpected_mem_txn", {31'h0, act}, 64'h1_FFFF_FFFF_F);
        else                   chk("mem_txn", {31'h0, act}, {31'h0, exp_q.pop_front()});
      end
      hold_pend = bus.mem_req && !bus.mem_ack;
      hold_val  = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      if (bus.reg_en && bus.reg_wr_en) begin
        reg_wr_cnt++;
        ract = {bus.reg_sel, bus.reg_wdata};
        if (rexp_q.size() == 0) chk("unexpected_reg_wr", {45'h0, ract}, 64'hF_FFFF_FFFF);
        else                    chk("reg_wr", {45'h0, ract}, {45'h0, rexp_q.pop_front()});
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rf_set(input logic [15:0] seed, input bit rnd);
    for (int i = 0; i < NUM_REGS; i++) begin
      ref_rf[i] = rnd ? 16'($urandom) : seed + 16'(i);
      rf_pre[i] = ref_rf[i];
    end
    rf_load = 1'b1;
    @(posedge clk);
    #1 rf_load = 1'b0;
  endtask

  task automatic mem_poke(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a] = d;
    pl_addr = a;
    pl_data = d;
    pl_mem  = 1'b1;
    @(posedge clk);
    #2 pl_mem = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < NUM_REGS; i++) chk({tag, "_rf"}, {48'h0, rf[i]}, {48'h0, ref_rf[i]});
  endtask

  // Starts a sequence, waits for done, and checks latency and drained queues.
  task automatic run_seq(input bit sv, input bit rs, input logic [15:0] base,
                         input int lat, input int poke);
    int  start_cyc, d0;
    bit  got;
    d0  = done_cnt;
    got = 1'b0;
    @(negedge clk);
    bus.start_save    = sv;
    bus.start_restore = rs;
    bus.base_addr     = base;
    start_cyc = cyc;
    @(negedge clk);
    bus.start_save    = 1'b0;
    bus.start_restore = 1'b0;
    bus.base_addr     = 16'($urandom);
    #1 chk("busy_after_start", {63'h0, bus.busy}, 64'h1);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #1;
      if (poke > 0) bus.start_restore = (k == poke);
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    bus.start_restore = 1'b0;
    chk("done_seen", {63'h0, got}, 64'h1);
    chk("busy_at_fin", {63'h0, bus.busy}, 64'h0);
    if (lat > 0) chk("done_latency", 64'(done_cyc - start_cyc), 64'(lat));
    if (poke > 0) begin
      repeat (40) @(negedge clk);
      chk("single_done", 64'(done_cnt - d0), 64'h1);
    end
    chk("mem_q_drained", 64'(exp_q.size()), 64'h0);
    chk("reg_q_drained", 64'(rexp_q.size()), 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          w0;
    bit          got;
    logic [15:0] base;
    bus.start_save    = 1'b0;
    bus.start_restore = 1'b0;
    bus.base_addr     = 16'h0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",      {63'h0, bus.busy},      64'h0);
    chk("rst_done",      {63'h0, bus.done},      64'h0);
    chk("rst_reg_en",    {63'h0, bus.reg_en},    64'h0);
    chk("rst_reg_wr_en", {63'h0, bus.reg_wr_en}, 64'h0);
    chk("rst_reg_sel",   64'(bus.reg_sel),       64'h0);
    chk("rst_reg_wdata", {48'h0, bus.reg_wdata}, 64'h0);
    chk("rst_mem_req",   {63'h0, bus.mem_req},   64'h0);
    chk("rst_mem_we",    {63'h0, bus.mem_we},    64'h0);
    chk("rst_mem_addr",  {48'h0, bus.mem_addr},  64'h0);
    chk("rst_mem_wdata", {48'h0, bus.mem_wdata}, 64'h0);
    chk("rst_state",     64'(bus.dbg_state),     64'(ST_IDLE));
    rst = 1'b0;

    // save, zero-wait memory
    rf_set(16'h1110, 1'b0);
    mem_delay = 0;
    model_save(16'h0200);
    run_seq(1'b1, 1'b0, 16'h0200, 25, 0);
    check_rf("save0");

    // restore with three wait states per request
    for (int i = 0; i < NUM_REGS; i++) mem_poke(16'h0400 + 16'(2 * i), 16'hA000 + 16'(i));
    mem_delay = 3;
    model_restore(16'h0400, NUM_REGS);
    w0 = reg_wr_cnt;
    run_seq(1'b0, 1'b1, 16'h0400, 0, 0);
    chk("restore_wr_pulses", 64'(reg_wr_cnt - w0), 64'(NUM_REGS));
    check_rf("restore_wait");

    // simultaneous starts: save wins; a restore while busy is ignored
    rf_set(16'h0, 1'b1);
    mem_delay = 1;
    model_save(16'h0800);
    run_seq(1'b1, 1'b1, 16'h0800, 0, 5);

    // address wrap
    rf_set(16'h0, 1'b1);
    mem_delay = 0;
    model_save(16'hFFFC);
    run_seq(1'b1, 1'b0, 16'hFFFC, 25, 0);

    // reset during the fourth restore request
    for (int i = 0; i < NUM_REGS; i++) mem_poke(16'h0600 + 16'(2 * i), 16'($urandom));
    rf_set(16'h0, 1'b1);
    mem_delay = 4;
    model_restore(16'h0600, 3);
    w0  = reg_wr_cnt;
    got = 1'b0;
    @(negedge clk);
    bus.start_restore = 1'b1;
    bus.base_addr     = 16'h0600;
    @(negedge clk);
    bus.start_restore = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (reg_wr_cnt - w0 == 3) begin
        got = 1'b1;
        break;
      end
    end
    chk("abort_reached_r2", {63'h0, got}, 64'h1);
    @(negedge clk);
    #1 chk("abort_req_pending", {63'h0, bus.mem_req}, 64'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_mem_req", {63'h0, bus.mem_req}, 64'h0);
    chk("abort_busy",    {63'h0, bus.busy},    64'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_more_wr", 64'(reg_wr_cnt - w0), 64'h3);
    chk("abort_mem_q", 64'(exp_q.size()), 64'h0);
    check_rf("abort");

    // back-to-back save then restore in the first idle cycle
    rf_set(16'h0, 1'b1);
    mem_delay = 2;
    model_save(16'h1000);
    run_seq(1'b1, 1'b0, 16'h1000, 0, 0);
    mem_delay = 0;
    model_restore(16'h1000, NUM_REGS);
    run_seq(1'b0, 1'b1, 16'h1000, 17, 0);
    check_rf("roundtrip");

    // randomized sequences
    for (int r = 0; r < 8; r++) begin
      base      = 16'($urandom) & 16'hFFFE;
      mem_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        rf_set(16'h0, 1'b1);
        model_save(base);
        run_seq(1'b1, 1'b0, base, (mem_delay == 0) ? 25 : 0, 0);
      end else begin
        for (int i = 0; i < NUM_REGS; i++) mem_poke(base + 16'(2 * i), 16'($urandom));
        model_restore(base, NUM_REGS);
        run_seq(1'b0, 1'b1, base, (mem_delay == 0) ? 17 : 0, 0);
      end
      check_rf("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
